// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master to single-slave bus arbiter, registered one-hot grant,
// optional master-0 priority, round-robin otherwise. BUS_TIMEOUT_EN adds a grant timeout.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int PRIO_M0        = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [NUM_MASTERS-1:0]          i_m_cs,
    input  logic [NUM_MASTERS-1:0]          i_m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   i_m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   i_m_dat,
    output logic [DATA_W-1:0]               o_m_dat,
    output logic [NUM_MASTERS-1:0]          o_m_ack,
    output logic [NUM_MASTERS-1:0]          o_m_grant,
    output logic                            o_m_err,
    output logic [ADDR_W-1:0]               o_addr,
    output logic [DATA_W-1:0]               o_dat,
    output logic                            o_cs,
    output logic                            o_we,
    input  logic [DATA_W-1:0]               i_dat,
    input  logic                            i_ack
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       gidx;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    logic                   win_vld;
    logic                   g_cs;
    logic                   to_hit;

    // Scan last+1, last+2, ... so the most recently served master ranks last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (PRIO_M0 != 0 && i_m_cs[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                cand = IDX_W'((int'(last) + i) % NUM_MASTERS);
                if (!win_vld && i_m_cs[cand] && !(PRIO_M0 != 0 && cand == '0)) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (grant[k]) gidx = IDX_W'(k);
    end

    assign g_cs = |(grant & i_m_cs);

    always_comb begin
        o_addr = '0;
        o_dat  = '0;
        o_we   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant[k]) begin
                o_addr = i_m_addr[k*ADDR_W +: ADDR_W];
                o_dat  = i_m_dat[k*DATA_W +: DATA_W];
                o_we   = i_m_we[k];
            end
        end
    end

    assign o_cs      = g_cs;
    assign o_m_dat   = i_dat;
    assign o_m_grant = grant;
    assign o_m_ack   = grant & i_m_cs & {NUM_MASTERS{i_ack | to_hit}};
    // A real ack in the timeout cycle completes normally, without error.
    assign o_m_err   = to_hit & ~i_ack & g_cs;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            to_cnt <= '0;
        else if (state != BUSY)
            to_cnt <= '0;
        else if (!i_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (state == BUSY) && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = ^{1'b0, TIMEOUT_CYCLES};
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant <= NUM_MASTERS'(1) << win_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Abort leaves the round-robin pointer untouched.
                    if (!g_cs) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (i_ack || to_hit) begin
                        grant <= '0;
                        last  <= gidx;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Random-traffic scoreboard bench for bus_arbiter_rr, followed by directed scenarios.
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cs, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_dat;
    logic [AW-1:0]   addr_a [N];
    logic [DW-1:0]   dat_a  [N];
    logic [DW-1:0]   o_m_dat, o_dat, s_dat;
    logic [AW-1:0]   o_addr;
    logic [N-1:0]    o_m_ack, o_m_grant;
    logic            o_m_err, o_cs, o_we, s_ack;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW] = addr_a[k];
            m_dat[k*DW +: DW]  = dat_a[k];
        end
    end

    bus_arbiter_rr #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_M0(1), .TIMEOUT_CYCLES(15)) dut (
        .i_clk(clk), .i_reset(rst), .i_m_cs(m_cs), .i_m_we(m_we), .i_m_addr(m_addr),
        .i_m_dat(m_dat), .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_grant(o_m_grant),
        .o_m_err(o_m_err), .o_addr(o_addr), .o_dat(o_dat), .o_cs(o_cs), .o_we(o_we),
        .i_dat(s_dat), .i_ack(s_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } txn_t;

    txn_t sb[$];

    bit            model_en = 1'b0;
    bit            dir_en   = 1'b0;
    bit            m_busy   = 1'b0;
    logic [IW-1:0] m_g      = '0;
    logic [IW-1:0] m_last   = '0;

    // Reference: master 0 always first; else the requester at the smallest
    // circular distance after the last completed master.
    function automatic logic [IW-1:0] pick();
        int best = 0;
        int bd   = N + 1;
        int d;
        if (m_cs[0]) return '0;
        for (int k = 1; k < N; k++) begin
            d = (k - int'(m_last) - 1 + 2 * N) % N;
            if (m_cs[k] && d < bd) begin
                bd   = d;
                best = k;
            end
        end
        return IW'(best);
    endfunction

    always @(posedge clk) begin
        if (model_en && !rst) begin
            if (!m_busy) begin
                if (m_cs != '0) begin
                    m_g    = pick();
                    m_busy = 1'b1;
                    sb.push_back('{m_g, m_we[m_g], addr_a[m_g], dat_a[m_g]});
                end
            end else if (!m_cs[m_g]) begin
                m_busy = 1'b0;
            end else if (s_ack) begin
                m_busy = 1'b0;
                m_last = m_g;
            end
        end
    end

    int            checks   = 0;
    int            failures = 0;
    logic [N-1:0]  prev_g = '0, ack_seen = '0, gnt_seen = '0;
    logic [N-1:0]  dexp_grant, dexp_ack, eg;
    logic          dexp_cs, dexp_we, dexp_err;
    logic [AW-1:0] dexp_addr;
    logic [DW-1:0] dexp_dat;
    txn_t          e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_en) begin
            eg = m_busy ? (N'(1) << m_g) : '0;
            chk("grant", 32'(o_m_grant), 32'(eg));
            chk("cs", 32'(o_cs), 32'(m_busy && m_cs[m_g]));
            chk("ack", 32'(o_m_ack), 32'((m_busy && m_cs[m_g] && s_ack) ? eg : '0));
            chk("err", 32'(o_m_err), 32'(0));
            chk("rdata", 32'(o_m_dat), 32'(s_dat));
            if (o_m_grant != '0 && prev_g == '0) begin
                chk("sb_pending", 32'(sb.size() != 0), 32'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("txn_grant", 32'(o_m_grant), 32'(N'(1) << e.idx));
                    chk("txn_addr", 32'(o_addr), 32'(e.addr));
                    chk("txn_we", 32'(o_we), 32'(e.we));
                    chk("txn_dat", 32'(o_dat), 32'(e.dat));
                end
            end
        end else if (dir_en) begin
            chk("d_grant", 32'(o_m_grant), 32'(dexp_grant));
            chk("d_cs", 32'(o_cs), 32'(dexp_cs));
            chk("d_ack", 32'(o_m_ack), 32'(dexp_ack));
            chk("d_err", 32'(o_m_err), 32'(dexp_err));
            chk("d_rdata", 32'(o_m_dat), 32'(s_dat));
            chk("d_addr", 32'(o_addr), 32'(dexp_grant != '0 ? dexp_addr : '0));
            chk("d_we", 32'(o_we), 32'(dexp_grant != '0 ? dexp_we : 1'b0));
            chk("d_dat", 32'(o_dat), 32'(dexp_grant != '0 ? dexp_dat : '0));
        end
        ack_seen = o_m_ack;
        gnt_seen = o_m_grant;
        prev_g   = o_m_grant;
    end

    int s_cnt = 0;

    task automatic new_txn(input int k);
        m_cs[k]   = 1'b1;
        m_we[k]   = 1'($urandom);
        addr_a[k] = AW'($urandom);
        dat_a[k]  = DW'($urandom);
    endtask

    task automatic drive_masters();
        for (int k = 0; k < N; k++) begin
            if (m_cs[k]) begin
                if (ack_seen[k]) begin
                    if ($urandom_range(2) == 0) new_txn(k);
                    else m_cs[k] = 1'b0;
                end else if (gnt_seen[k] && $urandom_range(15) == 0) begin
                    m_cs[k] = 1'b0;
                end
            end else if ($urandom_range(3) == 0) begin
                new_txn(k);
            end
        end
    endtask

    task automatic slave_auto();
        if (o_cs) begin
            if (s_cnt == 0) begin
                s_ack = 1'b1;
                s_dat = DW'($urandom);
            end else begin
                s_cnt--;
                s_ack = 1'b0;
            end
        end else begin
            s_ack = 1'b0;
            s_cnt = $urandom_range(3);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_idle();
        dexp_grant = '0;
        dexp_cs    = 1'b0;
        dexp_ack   = '0;
        dexp_err   = 1'b0;
        dexp_addr  = '0;
        dexp_we    = 1'b0;
        dexp_dat   = '0;
    endtask

    task automatic exp_gnt(input int k, input bit a, input bit er);
        dexp_grant = N'(1) << k;
        dexp_cs    = m_cs[k];
        dexp_addr  = addr_a[k];
        dexp_we    = m_we[k];
        dexp_dat   = dat_a[k];
        dexp_ack   = a ? (N'(1) << k) : '0;
        dexp_err   = er;
    endtask

    initial begin
        rst = 1'b1;
        m_cs = '0;
        m_we = '0;
        s_ack = 1'b0;
        s_dat = '0;
        for (int k = 0; k < N; k++) begin
            addr_a[k] = '0;
            dat_a[k]  = '0;
        end
        exp_idle();
        dir_en = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        dir_en   = 1'b0;
        model_en = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1 drive_masters();
            #1 slave_auto();
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 m_cs = '0;
            #1 slave_auto();
        end

        cyc();
        model_en = 1'b0;
        s_ack    = 1'b0;
        exp_idle();
        dir_en   = 1'b1;
        for (int k = 0; k < N; k++) begin
            addr_a[k] = AW'(16'h0100 * (k + 1));
            dat_a[k]  = DW'(16'h1111 * (k + 1));
        end
        addr_a[2] = 16'h1234;
        dat_a[2]  = 16'hBEEF;
        m_we      = 4'b0100;

        // m2 write, slave acks three cycles after o_cs rises
        cyc(); m_cs[2] = 1'b1; exp_idle();
        for (int i = 0; i < 4; i++) begin
            cyc(); s_ack = (i == 3); exp_gnt(2, i == 3, 1'b0);
        end
        cyc(); s_ack = 1'b0; m_cs[2] = 1'b0; exp_idle();

        // m1 read while m0 and m2 queue up; m0 wins next despite rr order
        cyc(); m_cs[1] = 1'b1; exp_idle();
        cyc(); m_cs[0] = 1'b1; m_cs[2] = 1'b1; exp_gnt(1, 1'b0, 1'b0);
        cyc(); s_ack = 1'b1; s_dat = 16'hA55A; exp_gnt(1, 1'b1, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[1] = 1'b0; exp_idle();
        cyc(); s_ack = 1'b1; exp_gnt(0, 1'b1, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[0] = 1'b0; exp_idle();
        cyc(); s_ack = 1'b1; exp_gnt(2, 1'b1, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[2] = 1'b0; m_cs[3] = 1'b1; exp_idle();

        // m3 aborts; pointer stays at m2 so m3 still beats m2 afterwards
        cyc(); exp_gnt(3, 1'b0, 1'b0);
        cyc(); m_cs[3] = 1'b0; s_ack = 1'b1; exp_gnt(3, 1'b0, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[2] = 1'b1; m_cs[3] = 1'b1; exp_idle();
        cyc(); s_ack = 1'b1; exp_gnt(3, 1'b1, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[3] = 1'b0; exp_idle();
        cyc(); s_ack = 1'b1; exp_gnt(2, 1'b1, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[2] = 1'b0; exp_idle();

        // silent slave
        cyc(); m_cs[1] = 1'b1; exp_idle();
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            cyc(); exp_gnt(1, 1'b0, 1'b0);
        end
        cyc(); exp_gnt(1, 1'b1, 1'b1);
        cyc(); m_cs[1] = 1'b0; exp_idle();
`else
        for (int i = 0; i < 110; i++) begin
            cyc(); exp_gnt(1, 1'b0, 1'b0);
        end
        cyc(); s_ack = 1'b1; exp_gnt(1, 1'b1, 1'b0);
        cyc(); s_ack = 1'b0; m_cs[1] = 1'b0; exp_idle();
`endif

        // reset mid-transaction drops the grant at once, ack suppressed
        cyc(); m_cs[2] = 1'b1; exp_idle();
        cyc(); exp_gnt(2, 1'b0, 1'b0);
        cyc(); rst = 1'b1; s_ack = 1'b1; exp_idle();
        cyc(); rst = 1'b0; s_ack = 1'b0; m_cs[2] = 1'b0; exp_idle();
        cyc(); exp_idle();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
N-master to single-slave bus arbiter for the shared 16-bit memory bus. It replaces the fixed two-master mux with a parametrised arbiter that registers the grant and holds it for the whole transaction. Master 0 (the video fetch) optionally has absolute priority, and the remaining masters are served round-robin. It sits between the masters (VGA fetch, UART master, future CPU/DMA) and the memory/slave decode.

Parameters:
- NUM_MASTERS, 4: number of requesting masters; range 2..8.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- PRIO_M0, 1: 1 = master 0 wins over all others whenever requesting; 0 = master 0 joins the round-robin.
- TIMEOUT_CYCLES, 15: maximum cycles a grant waits for i_ack. Used only with BUS_TIMEOUT_EN.

Ports:
- i_clk, in, 1: system clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_m_cs, in, NUM_MASTERS: per-master request/chip-select. Held high until that master's ack.
- i_m_we, in, NUM_MASTERS: per-master write enable.
- i_m_addr, in, NUM_MASTERS*ADDR_W: packed addresses. Master k occupies bits [k*ADDR_W +: ADDR_W].
- i_m_dat, in, NUM_MASTERS*DATA_W: packed write data, same packing.
- o_m_dat, out, DATA_W: read data broadcast to all masters; equals i_dat.
- o_m_ack, out, NUM_MASTERS: per-master ack; one-hot or zero.
- o_m_grant, out, NUM_MASTERS: registered one-hot grant, or zero.
- o_m_err, out, 1: bus error strobe, qualified by o_m_ack.
- o_addr, out, ADDR_W: slave-side address.
- o_dat, out, DATA_W: slave-side write data.
- o_cs, out, 1: slave-side chip select.
- o_we, out, 1: slave-side write enable.
- i_dat, in, DATA_W: slave read data.
- i_ack, in, 1: slave ack.

Behaviour:
- Reset values (asynchronous): o_m_grant=0, state=IDLE, rr pointer last=0, timeout counter=0. Derived outputs are then o_cs=0, o_we=0, o_addr=0, o_dat=0, o_m_ack=0, o_m_err=0.
- Slave-side outputs are muxed from the granted master. With no grant: o_cs=0, o_we=0, o_addr=0, o_dat=0.
- o_cs = |(o_m_grant & i_m_cs). If the granted master drops cs, o_cs falls in the same cycle.
- o_m_ack[k] = o_m_grant[k] & i_ack & i_m_cs[k]. This is combinational, with zero latency from i_ack.
- FSM states:
  - IDLE: if any i_m_cs is high, register the winner's grant bit and go to BUSY. Otherwise stay.
  - BUSY, normal completion: on the ack cycle, clear the grant, set last=granted index, go to IDLE.
  - BUSY, abort: if the granted master's cs is low, clear the grant and go to IDLE. last is unchanged and no ack is issued.
- Winner selection:
  - PRIO_M0=1 and i_m_cs[0] high: master 0 wins.
  - Otherwise: the first requesting index scanning last+1, last+2, ... modulo NUM_MASTERS. With PRIO_M0=1, index 0 is skipped in the scan.
- Latency: a request seen at edge k gives grant and o_cs valid after edge k+1. Minimum transaction is 2 cycles (grant cycle with ack). There is always one IDLE cycle between transactions. A master holding cs after its ack re-competes in that IDLE cycle.
- Grant is never preempted: a master 0 request arriving during BUSY waits for the current transaction to end.
- Ack while in IDLE or with no grant is ignored.
- Reset asserted mid-transaction: the grant drops immediately and no ack is issued.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without i_ack.
  - When the count reaches TIMEOUT_CYCLES, the arbiter pulses o_m_ack[granted]=1 and o_m_err=1 for one cycle, releases the grant, sets last, and goes to IDLE.
  - Real i_ack arriving in the same cycle wins: normal ack, o_m_err=0.
- BUS_TIMEOUT_EN undefined: no counter, o_m_err tied 0, and the grant is held indefinitely until ack or abort.

Test Plan:
- Single master: m2 write, addr 0x1234, dat 0xBEEF; slave acks 3 cycles after o_cs -> o_addr=0x1234, o_we=1, o_dat=0xBEEF while granted; o_m_ack=4'b0100 for exactly one cycle; grant 0 the next cycle.
- Round-robin (PRIO_M0=1): m1, m2, m3 request continuously, each acked immediately -> grant order m1, m2, m3, m1, with one IDLE cycle between grants.
- Priority: m0 requests while m1 is BUSY -> m1 completes unpreempted; m0 is granted next, ahead of waiting m2.
- Abort: m3 granted, drops cs before ack -> o_cs low the same cycle, grant cleared the next edge, no ack, rr pointer unchanged (next contender after m2 is still m3).
- Read path: m1 read, slave returns i_dat=0xA55A with ack -> o_m_dat=0xA55A and o_m_ack[1]=1 in the same cycle.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=15): slave never acks -> exactly 15 BUSY cycles, then o_m_ack[granted]=1 and o_m_err=1 for one cycle, grant released; without the macro the grant is held for ≥100 cycles.
